// File: rtl/uart_loader.sv
// -----------------------------------------------------------------------------
// uart_loader
//
// Consumes the UART receiver's byte stream and parses a program-load frame:
//   SYNC_BYTE, LEN_LO, LEN_HI, LEN x {b0, b1, b2, b3}, CSUM
// Each 4-byte group is assembled little-endian (b0 -> bits [7:0]) and written
// to instruction memory at consecutive word addresses starting at 0. CSUM is the
// low 8 bits of the sum of LEN_LO, LEN_HI and every data byte. The CPU is held
// while a frame is in flight. The result is reported through two sticky flags.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous, active-high reset
//   rx_byte        in   received byte, meaningful while rx_byte_valid is high
//   rx_byte_valid  in   single-cycle strobe, one per received byte
//   imem_we        out  instruction-memory write enable (one-cycle pulse)
//   imem_addr      out  word address of the write (held between writes)
//   imem_wdata     out  word to write (held between writes)
//   cpu_hold       out  high while a frame is being received
//   load_done      out  sticky: last frame completed with a good checksum
//   load_error     out  sticky: last frame failed (length, checksum, timeout)
// -----------------------------------------------------------------------------
module uart_loader #(
  parameter int          ADDR_WIDTH     = 10,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_byte_valid,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  // Largest acceptable word count; one bit wider than LEN so 2**16 still fits.
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  // Inter-byte timer. The exit to ERR is taken on the edge where the count
  // would reach TIMEOUT_CYCLES-1, so the error flag shows up exactly
  // TIMEOUT_CYCLES cycles after the last byte's strobe cycle.
  localparam int              TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

  state_t                  state_q;
  logic [7:0]              len_lo_q;
  logic [15:0]             len_q;
  logic [7:0]              sum_q;
  logic [23:0]             asm_q;       // first three bytes of the word in flight
  logic [1:0]              byte_cnt_q;
  logic [15:0]             word_idx_q;
  logic [TMO_W-1:0]        tmo_cnt_q;

  logic                    imem_we_q;
  logic [ADDR_WIDTH-1:0]   imem_addr_q;
  logic [31:0]             imem_wdata_q;
  logic                    cpu_hold_q;
  logic                    load_done_q;
  logic                    load_error_q;

  // Next values that several states share.
  logic [7:0]              sum_d;
  logic [15:0]             len_d;
  logic [31:0]             word_d;
  logic                    in_frame;
  logic                    tmo_hit;

  assign sum_d    = sum_q + rx_byte;
  assign len_d    = {rx_byte, len_lo_q};
  assign word_d   = {rx_byte, asm_q};
  assign in_frame = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);
  // Only consulted when no byte arrives this cycle, so a byte always wins.
  assign tmo_hit  = in_frame && (tmo_cnt_q == TMO_LAST);

  // NOTE: all state below is assigned with <= so every register samples the
  // values from before this edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      sum_q        <= '0;
      asm_q        <= '0;
      byte_cnt_q   <= '0;
      word_idx_q   <= '0;
      tmo_cnt_q    <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      // Write enable is a pulse; only the 4th data byte raises it.
      imem_we_q <= 1'b0;

      if (rx_byte_valid) begin
        tmo_cnt_q <= '0;
      end else if (in_frame) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end

      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (rx_byte_valid && (rx_byte == SYNC_BYTE)) begin
            state_q      <= S_LEN_LO;
            sum_q        <= '0;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
          end
        end

        S_LEN_LO: begin
          if (rx_byte_valid) begin
            len_lo_q <= rx_byte;
            sum_q    <= sum_d;
            state_q  <= S_LEN_HI;
          end else if (tmo_hit) begin
            state_q      <= S_ERR;
            cpu_hold_q   <= 1'b0;
            load_error_q <= 1'b1;
          end
        end

        S_LEN_HI: begin
          if (rx_byte_valid) begin
            len_q <= len_d;
            sum_q <= sum_d;
            if (len_d == 16'd0) begin
              state_q <= S_CSUM;
            end else if ({1'b0, len_d} > MAX_WORDS) begin
              state_q      <= S_ERR;
              cpu_hold_q   <= 1'b0;
              load_error_q <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end else if (tmo_hit) begin
            state_q      <= S_ERR;
            cpu_hold_q   <= 1'b0;
            load_error_q <= 1'b1;
          end
        end

        S_DATA: begin
          if (rx_byte_valid) begin
            sum_q      <= sum_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            asm_q      <= {rx_byte, asm_q[23:8]};
            if (byte_cnt_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= word_idx_q[ADDR_WIDTH-1:0];
              imem_wdata_q <= word_d;
              word_idx_q   <= word_idx_q + 16'd1;
              if (word_idx_q == (len_q - 16'd1)) begin
                state_q <= S_CSUM;
              end
            end
          end else if (tmo_hit) begin
            state_q      <= S_ERR;
            cpu_hold_q   <= 1'b0;
            load_error_q <= 1'b1;
          end
        end

        S_CSUM: begin
          if (rx_byte_valid) begin
            cpu_hold_q <= 1'b0;
            if (rx_byte == sum_q) begin
              state_q     <= S_DONE;
              load_done_q <= 1'b1;
            end else begin
              state_q      <= S_ERR;
              load_error_q <= 1'b1;
            end
          end else if (tmo_hit) begin
            state_q      <= S_ERR;
            cpu_hold_q   <= 1'b0;
            load_error_q <= 1'b1;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          cpu_hold_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_loader
//
// Directed bench for uart_loader (ADDR_WIDTH=10, TIMEOUT_CYCLES=100).
// A table of whole frames with hand-computed results is replayed first; then
// hand-written sequences cover cpu_hold timing, exact timeout distance, a byte
// arriving on the expiry cycle, reset in the middle of a word and the largest
// legal length.
// -----------------------------------------------------------------------------
module tb_uart_loader;

  localparam int AW  = 10;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_byte;
  logic          rx_byte_valid;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;

  uart_loader #(
    .ADDR_WIDTH    (AW),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor. gap = edges between the strobe edge of the last byte and
  // the cycle the write is seen; 0 means the pulse is in the very next cycle.
  int            cyc        = 0;
  int            strobe_cyc = 0;
  int            wr_total   = 0;
  logic [AW-1:0] wr_addr [64];
  logic [31:0]   wr_data [64];
  int            wr_gap  [64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_byte_valid) strobe_cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (wr_total < 64) begin
        wr_addr[wr_total] = imem_addr;
        wr_data[wr_total] = imem_wdata;
        wr_gap[wr_total]  = cyc - strobe_cyc;
      end
      wr_total = wr_total + 1;
    end
  end

  // Every helper starts and ends 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_byte_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    idle(1);
  endtask

  typedef struct {
    string            name;
    logic [0:15][7:0] bytes;
    int               n;
    logic             exp_done;
    logic             exp_err;
    int               exp_nw;
    logic [AW-1:0]    a0;
    logic [31:0]      d0;
    logic [AW-1:0]    a1;
    logic [31:0]      d1;
  } vec_t;

  localparam int NV = 6;
  vec_t tbl [NV];

  int base;
  int last;

  initial begin
    tbl[0] = '{"two_word",
               {8'h00, 8'hFF, 8'h12, 8'hA5, 8'h02, 8'h00, 8'h78, 8'h56,
                8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4E, {1{8'h00}}},
               15, 1'b1, 1'b0, 2, 10'd0, 32'h12345678, 10'd1, 32'hDEADBEEF};
    tbl[1] = '{"zero_len",
               {8'hA5, 8'h00, 8'h00, 8'h00, {12{8'h00}}},
               4, 1'b1, 1'b0, 0, 10'd0, 32'h0, 10'd0, 32'h0};
    tbl[2] = '{"bad_csum",
               {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF,
                8'hBE, 8'hAD, 8'hDE, 8'h4F, {4{8'h00}}},
               12, 1'b0, 1'b1, 2, 10'd0, 32'h12345678, 10'd1, 32'hDEADBEEF};
    tbl[3] = '{"good_after_bad",
               {8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAB, {8{8'h00}}},
               8, 1'b1, 1'b0, 1, 10'd0, 32'h11223344, 10'd0, 32'h0};
    tbl[4] = '{"len_overflow",
               {8'hA5, 8'h01, 8'h04, {13{8'h00}}},
               3, 1'b0, 1'b1, 0, 10'd0, 32'h0, 10'd0, 32'h0};
    tbl[5] = '{"sync_as_data",
               {8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h95, {8{8'h00}}},
               8, 1'b1, 1'b0, 1, 10'd0, 32'hA5A5A5A5, 10'd0, 32'h0};

    rst           = 1'b1;
    rx_byte       = 8'h00;
    rx_byte_valid = 1'b0;
    @(posedge clk);
    #1;
    idle(2);
    check("rst_we",    imem_we,    0);
    check("rst_addr",  imem_addr,  0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_hold",  cpu_hold,   0);
    check("rst_done",  load_done,  0);
    check("rst_err",   load_error, 0);
    rst = 1'b0;
    idle(1);

    // ---------------- table of whole frames ----------------
    for (int i = 0; i < NV; i++) begin
      base = wr_total;
      for (int j = 0; j < tbl[i].n; j++) send_gap(tbl[i].bytes[j]);
      idle(2);
      check({tbl[i].name, "_done"},   load_done,       tbl[i].exp_done);
      check({tbl[i].name, "_err"},    load_error,      tbl[i].exp_err);
      check({tbl[i].name, "_hold"},   cpu_hold,        0);
      check({tbl[i].name, "_nwrite"}, wr_total - base, tbl[i].exp_nw);
      if (tbl[i].exp_nw > 0) begin
        check({tbl[i].name, "_addr0"}, wr_addr[base], tbl[i].a0);
        check({tbl[i].name, "_data0"}, wr_data[base], tbl[i].d0);
        check({tbl[i].name, "_gap0"},  wr_gap[base],  0);
      end
      if (tbl[i].exp_nw > 1) begin
        check({tbl[i].name, "_addr1"}, wr_addr[base+1], tbl[i].a1);
        check({tbl[i].name, "_data1"}, wr_data[base+1], tbl[i].d1);
        check({tbl[i].name, "_gap1"},  wr_gap[base+1],  0);
      end
      if (tbl[i].exp_nw > 0) begin
        // Address and data must hold the last write once imem_we is low.
        last = (tbl[i].exp_nw > 1) ? 1 : 0;
        check({tbl[i].name, "_we_low"},    imem_we,    0);
        check({tbl[i].name, "_addr_hold"}, imem_addr,  last ? tbl[i].a1 : tbl[i].a0);
        check({tbl[i].name, "_data_hold"}, imem_wdata, last ? tbl[i].d1 : tbl[i].d0);
      end
    end

    // ---------------- cpu_hold window on a zero-length frame ----------------
    check("zl_hold_pre", cpu_hold, 0);
    send_byte(8'hA5);
    check("zl_hold_sync", cpu_hold, 1);
    check("zl_done_clr",  load_done, 0);
    idle(1);
    send_gap(8'h00);
    send_byte(8'h00);
    check("zl_hold_lenhi", cpu_hold, 1);
    idle(1);
    send_byte(8'h00);
    check("zl_hold_csum", cpu_hold,  0);
    check("zl_done",      load_done, 1);

    // ---------------- timeout: error exactly TMO cycles after last strobe ----
    idle(1);
    base = wr_total;
    send_gap(8'h00);
    send_gap(8'hFF);
    send_gap(8'h12);
    send_gap(8'hA5);
    send_gap(8'h01);
    send_gap(8'h00);
    send_byte(8'h78);
    idle(TMO - 2);
    check("tmo_err_early",  load_error, 0);
    check("tmo_hold_early", cpu_hold,   1);
    idle(1);
    check("tmo_err",    load_error, 1);
    check("tmo_hold",   cpu_hold,   0);
    check("tmo_done",   load_done,  0);
    check("tmo_nwrite", wr_total - base, 0);

    // ---------------- byte on the expiry cycle wins ----------------
    idle(1);
    base = wr_total;
    send_gap(8'hA5);
    send_gap(8'h01);
    send_byte(8'h00);
    idle(TMO - 2);
    send_byte(8'h44);
    check("race_err",  load_error, 0);
    check("race_hold", cpu_hold,   1);
    idle(1);
    send_gap(8'h33);
    send_gap(8'h22);
    send_gap(8'h11);
    send_gap(8'hAB);
    check("race_done",   load_done,       1);
    check("race_nwrite", wr_total - base, 1);
    check("race_data",   wr_data[base],   32'h11223344);

    // ---------------- reset between bytes 2 and 3 of a word ----------------
    base = wr_total;
    send_gap(8'hA5);
    send_gap(8'h02);
    send_gap(8'h00);
    send_gap(8'h78);
    send_gap(8'h56);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_we",    imem_we,    0);
    check("mid_rst_addr",  imem_addr,  0);
    check("mid_rst_wdata", imem_wdata, 0);
    check("mid_rst_hold",  cpu_hold,   0);
    check("mid_rst_done",  load_done,  0);
    check("mid_rst_err",   load_error, 0);
    idle(2);
    check("mid_rst_nwrite", wr_total - base, 0);
    // Old frame is gone: these bytes are noise in IDLE.
    send_gap(8'h34);
    send_gap(8'h12);
    check("mid_rst_idle_hold", cpu_hold, 0);
    for (int j = 0; j < 8; j++) begin
      logic [0:7][7:0] fr;
      fr = {8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAB};
      send_gap(fr[j]);
    end
    check("post_rst_done",   load_done,       1);
    check("post_rst_nwrite", wr_total - base, 1);
    check("post_rst_addr",   wr_addr[base],   0);
    check("post_rst_data",   wr_data[base],   32'h11223344);

    // ---------------- largest legal length (2**AW words) is accepted --------
    send_gap(8'hA5);
    send_gap(8'h00);
    send_gap(8'h04);
    check("max_len_err",  load_error, 0);
    check("max_len_hold", cpu_hold,   1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("max_len_rst_hold", cpu_hold, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
